// File: rtl/pipeline_reg_pkg.sv
// Shared constants and the occupancy encoding for the pipeline_reg skid-buffer slice.
package pipeline_reg_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // Number of words held by the slice: main only, or main plus skid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipeline_reg.sv
// pipeline_reg: full-throughput valid/ready register slice with a one-word skid buffer.
// Define PIPELINE_REG_DATA_RST_EN to give main_data/skid_data an asynchronous reset to 0.
module pipeline_reg
  import pipeline_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q,   in_ready_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic in_xfer;
  logic out_xfer;
  occ_e occ;

  always_comb begin
    in_xfer  = in_valid && in_ready_q;
    out_xfer = main_valid_q && out_ready;

    occ = OCC_EMPTY;
    if (skid_valid_q)      occ = OCC_FULL;
    else if (main_valid_q) occ = OCC_ONE;

    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    case (occ)
      OCC_EMPTY: begin
        if (in_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = in_data;
        end else if (in_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (out_xfer) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Registered ready: looks at next-cycle skid occupancy, never at out_ready directly.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef PIPELINE_REG_DATA_RST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// Self-checking bench for pipeline_reg: directed vector table, random stall scoreboard, mid-run reset.
module tb_pipeline_reg;
  import pipeline_reg_pkg::*;

  localparam int DW = DEFAULT_DATA_W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int n_chk;
  int n_fail;

  pipeline_reg #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic          exp_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic eov, input logic [DW-1:0] eod, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.exp_ov = eov; v.exp_od = eod; v.exp_ir = eir;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DW-1:0] sb[$];
  occ_e          occ_m;
  logic [DW-1:0] prev_od;
  logic          prev_stall;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset: outputs low while rst_n is asserted, in_ready rises after first edge.
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef PIPELINE_REG_DATA_RST_EN
    chk("rst_out_data", out_data, 32'd0);
`endif
    #8;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    next_cycle();
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef PIPELINE_REG_DATA_RST_EN
    chk("rel_out_data", out_data, 32'd0);
`endif

    // Expected outputs are the state seen before the edge that consumes the inputs.
    // Backpressure then drain
    add(1, 32'hA5A5A5A5, 0, 0, 32'h0,        1);
    add(1, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 1);
    add(1, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 0);
    add(0, 32'h0,        1, 1, 32'hA5A5A5A5, 0);
    add(0, 32'h0,        1, 1, 32'hA5A5A5A5, 1);
    add(0, 32'h0,        1, 0, 32'h0,        1);
    // Streaming
    add(1, 32'h1,        1, 0, 32'h0,        1);
    add(1, 32'h2,        1, 1, 32'h1,        1);
    add(1, 32'h3,        1, 1, 32'h2,        1);
    add(1, 32'h4,        1, 1, 32'h3,        1);
    add(0, 32'h0,        1, 1, 32'h4,        1);
    add(0, 32'h0,        1, 0, 32'h0,        1);
    // Distinct words through FULL, then simultaneous in/out while ONE
    add(1, 32'hDEADBEEF, 0, 0, 32'h0,        1);
    add(1, 32'h12345678, 0, 1, 32'hDEADBEEF, 1);
    add(1, 32'hFFFFFFFF, 0, 1, 32'hDEADBEEF, 0);
    add(0, 32'h0,        1, 1, 32'hDEADBEEF, 0);
    add(1, 32'hCAFEF00D, 1, 1, 32'h12345678, 1);
    add(0, 32'h0,        1, 1, 32'hCAFEF00D, 1);
    add(0, 32'h0,        0, 0, 32'h0,        1);

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ir});
      if (vecs[i].exp_ov)
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      next_cycle();
    end

    // Random stall with queue scoreboard; last 8 cycles drain.
    sb.delete();
    prev_stall = 1'b0;
    prev_od = '0;
    for (int c = 0; c < 1008; c++) begin
      in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      occ_m = (sb.size() == 0) ? OCC_EMPTY : (sb.size() == 1) ? OCC_ONE : OCC_FULL;
      chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, occ_m != OCC_EMPTY});
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, occ_m != OCC_FULL});
      if (prev_stall)
        chk("rnd_stall_hold", out_data, prev_od);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious_out", out_data, ~out_data);
        end else begin
          chk("rnd_out_data", out_data, sb[0]);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb.push_back(in_data);
      prev_stall = out_valid && !out_ready;
      prev_od = out_data;
      next_cycle();
    end
    chk("rnd_drained", 32'(sb.size()), 32'd0);

    // Reset mid-operation while FULL.
    in_valid = 1'b1; in_data = 32'h111; out_ready = 1'b0;
    next_cycle();
    in_data = 32'h222;
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("mid_full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_full_out_data", out_data, 32'h111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      #1;
      chk("post_rst_no_emit", {31'b0, out_valid}, 32'd0);
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
